// File: rtl/dmem_tag_responder.sv
// dmem_tag_responder: memory-side responder for the dcache_mem tagged request/response
// protocol. Hands out a nonzero tag the same cycle it accepts a LOAD/STORE, then
// broadcasts that tag (with load data) LATENCY cycles later, one completion per cycle.
// Optional build macro: MEM_BUSY_INJECT_EN adds LFSR-driven random refusal of commands.
module dmem_tag_responder #(
  parameter int unsigned BLOCK_SIZE = 64,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned NUM_TAGS   = 15,
  parameter int unsigned LATENCY    = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [1:0]            proc2mem_command,
  input  logic [ADDR_WIDTH-1:0] proc2mem_addr,
  input  logic [BLOCK_SIZE-1:0] proc2mem_data,
  output logic [3:0]            mem2proc_response,
  output logic [BLOCK_SIZE-1:0] mem2proc_data,
  output logic [3:0]            mem2proc_tag
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned CDW   = $clog2(LATENCY + 1);
  localparam logic [1:0]  CMD_LOAD  = 2'd1;
  localparam logic [1:0]  CMD_STORE = 2'd2;

  logic [BLOCK_SIZE-1:0] store_q [DEPTH];
  logic [NUM_TAGS-1:0]   valid_q;
  logic [NUM_TAGS-1:0]   is_load_q;
  logic [CDW-1:0]        count_q [NUM_TAGS];
  logic [BLOCK_SIZE-1:0] data_q  [NUM_TAGS];

  logic                  busy_c;
  logic                  load_c;
  logic                  req_c;
  logic                  accept_c;
  logic [3:0]            free_tag_c;
  logic [3:0]            win_tag_c;
  logic                  win_load_c;
  logic [BLOCK_SIZE-1:0] win_data_c;

`ifdef MEM_BUSY_INJECT_EN
  logic [7:0] lfsr_q;

  // Fibonacci LFSR (taps 8,6,5,4); refuses any command while its low two bits are zero.
  always_ff @(posedge clock) begin
    if (!reset) lfsr_q <= 8'hA5;
    else        lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  assign busy_c = (lfsr_q[1:0] == 2'b00);
`else
  assign busy_c = 1'b0;
`endif

  assign load_c = (proc2mem_command == CMD_LOAD);
  assign req_c  = load_c || (proc2mem_command == CMD_STORE);

  // Lowest free tag, from registered slot state only (a broadcasting slot is still busy).
  always_comb begin
    free_tag_c = 4'd0;
    for (int i = NUM_TAGS - 1; i >= 0; i--) begin
      if (!valid_q[i]) free_tag_c = 4'(i + 1);
    end
  end

  assign accept_c          = reset && req_c && !busy_c && (free_tag_c != 4'd0);
  assign mem2proc_response = accept_c ? free_tag_c : 4'd0;

  // Pick the lowest eligible tag for next cycle's broadcast, skipping the one on the bus now.
  always_comb begin
    win_tag_c  = 4'd0;
    win_load_c = 1'b0;
    win_data_c = '0;
    for (int i = NUM_TAGS - 1; i >= 0; i--) begin
      if (valid_q[i] && (count_q[i] <= CDW'(1)) && (mem2proc_tag != 4'(i + 1))) begin
        win_tag_c  = 4'(i + 1);
        win_load_c = is_load_q[i];
        win_data_c = data_q[i];
      end else if ((LATENCY == 1) && accept_c && (free_tag_c == 4'(i + 1))) begin
        win_tag_c  = 4'(i + 1);
        win_load_c = load_c;
        win_data_c = store_q[proc2mem_addr];
      end
    end
  end

  // Backing store, slot table and registered completion bus.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int a = 0; a < DEPTH; a++) store_q[a] <= '0;
      for (int i = 0; i < NUM_TAGS; i++) begin
        count_q[i] <= '0;
        data_q[i]  <= '0;
      end
      valid_q       <= '0;
      is_load_q     <= '0;
      mem2proc_tag  <= 4'd0;
      mem2proc_data <= '0;
    end else begin
      mem2proc_tag  <= win_tag_c;
      mem2proc_data <= win_load_c ? win_data_c : '0;
      if (accept_c && !load_c) store_q[proc2mem_addr] <= proc2mem_data;
      for (int i = 0; i < NUM_TAGS; i++) begin
        if (accept_c && (free_tag_c == 4'(i + 1))) begin
          valid_q[i]   <= 1'b1;
          count_q[i]   <= CDW'(LATENCY - 1);
          is_load_q[i] <= load_c;
          data_q[i]    <= load_c ? store_q[proc2mem_addr] : '0;
        end else if (valid_q[i] && (mem2proc_tag == 4'(i + 1))) begin
          valid_q[i] <= 1'b0;
        end else if (valid_q[i] && (count_q[i] != '0)) begin
          count_q[i] <= count_q[i] - CDW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_tag_responder.sv
// Bench for dmem_tag_responder: directed scenarios plus random traffic, checked every cycle
// against a request-list reference model (accept cycle + latency, lowest-tag arbitration).
// Honours MEM_BUSY_INJECT_EN when defined for the design.
module tb_dmem_tag_responder;

  localparam int unsigned BS  = 64;
  localparam int unsigned AW  = 10;
  localparam int unsigned NT  = 15;
  localparam int unsigned LAT = 16;

  logic          clock;
  logic          reset;
  logic [1:0]    proc2mem_command;
  logic [AW-1:0] proc2mem_addr;
  logic [BS-1:0] proc2mem_data;
  logic [3:0]    mem2proc_response;
  logic [BS-1:0] mem2proc_data;
  logic [3:0]    mem2proc_tag;

  dmem_tag_responder #(
    .BLOCK_SIZE(BS), .ADDR_WIDTH(AW), .NUM_TAGS(NT), .LATENCY(LAT)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .proc2mem_command (proc2mem_command),
    .proc2mem_addr    (proc2mem_addr),
    .proc2mem_data    (proc2mem_data),
    .mem2proc_response(mem2proc_response),
    .mem2proc_data    (mem2proc_data),
    .mem2proc_tag     (mem2proc_tag)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int          tag;
    int          acc;
    logic [63:0] data;
  } req_t;

  req_t        pend[$];
  logic [63:0] ref_mem [1 << AW];
  logic [7:0]  ref_lfsr;
  int          cyc;
  int          n_checks;
  int          n_fail;
  int          n_accepted;
  int          n_discarded;
  int          n_observed;
  logic [3:0]  obs_tag;
  logic [63:0] obs_data;

  task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at cycle %0d", name, got, exp, cyc);
    end
  endtask

  // Directed expectations assume no random refusals.
  task automatic expect_dir(input string name, input logic [63:0] got, input logic [63:0] exp);
`ifndef MEM_BUSY_INJECT_EN
    check_eq(name, got, exp);
`endif
  endtask

  task automatic model_clear();
    n_discarded += pend.size();
    pend.delete();
    foreach (ref_mem[a]) ref_mem[a] = 64'd0;
    ref_lfsr = 8'hA5;
  endtask

  // One clock cycle: drive, sample away from the edge, compare, advance the model.
  task automatic step(input logic rst, input logic [1:0] cmd, input logic [AW-1:0] addr,
                      input logic [63:0] wdata, output logic [3:0] resp);
    int         bidx;
    bit [15:0]  used;
    bit         busy;
    logic [3:0] exp_resp;
    @(negedge clock);
    reset            = rst;
    proc2mem_command = cmd;
    proc2mem_addr    = addr;
    proc2mem_data    = wdata;
    #1;
    bidx = -1;
    foreach (pend[k]) begin
      if ((pend[k].acc + int'(LAT) <= cyc) && (bidx < 0 || pend[k].tag < pend[bidx].tag)) bidx = k;
    end
    obs_tag  = mem2proc_tag;
    obs_data = mem2proc_data;
    if (obs_tag != 4'd0) n_observed++;
    check_eq("bcast_tag", 64'(mem2proc_tag), (bidx < 0) ? 64'd0 : 64'(pend[bidx].tag));
    check_eq("bcast_data", mem2proc_data, (bidx < 0) ? 64'd0 : pend[bidx].data);
    used = '0;
    foreach (pend[k]) used[pend[k].tag] = 1'b1;
    busy = 1'b0;
`ifdef MEM_BUSY_INJECT_EN
    busy = (ref_lfsr % 4 == 0);
`endif
    exp_resp = 4'd0;
    if (rst && (cmd == 2'd1 || cmd == 2'd2) && !busy) begin
      for (int t = int'(NT); t >= 1; t--) if (!used[t]) exp_resp = 4'(t);
    end
    resp = mem2proc_response;
    check_eq("response", 64'(resp), 64'(exp_resp));
    if (bidx >= 0) pend.delete(bidx);
    if (!rst) begin
      model_clear();
    end else begin
      if (exp_resp != 4'd0) begin
        n_accepted++;
        pend.push_back('{tag: int'(exp_resp), acc: cyc, data: (cmd == 2'd1) ? ref_mem[addr] : 64'd0});
        if (cmd == 2'd2) ref_mem[addr] = wdata;
      end
      ref_lfsr = {ref_lfsr[6:0], ^(ref_lfsr & 8'hB8)};
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    logic [3:0] r;
    for (int i = 0; i < n; i++) step(1'b1, 2'd0, '0, 64'd0, r);
  endtask

  task automatic drain();
    int         n;
    logic [3:0] r;
    n = 0;
    while (pend.size() != 0 && n < int'(4 * LAT * NT)) begin
      step(1'b1, 2'd0, '0, 64'd0, r);
      n++;
    end
    check_eq("drain_timeout", 64'(pend.size()), 64'd0);
  endtask

  initial begin
    logic [3:0] r;
    n_checks = 0; n_fail = 0; n_accepted = 0; n_discarded = 0; n_observed = 0; cyc = 0;
    reset = 1'b0; proc2mem_command = 2'd0; proc2mem_addr = '0; proc2mem_data = '0;
    model_clear();
    repeat (2) @(posedge clock);

    // Reset state, then T1: first load returns tag 1, completes LATENCY cycles later.
    step(1'b0, 2'd1, AW'(5), 64'd0, r);
    expect_dir("reset_resp", 64'(r), 64'd0);
    step(1'b1, 2'd1, AW'(5), 64'd0, r);
    expect_dir("t1_resp", 64'(r), 64'd1);
    idle(int'(LAT) - 1);
    step(1'b1, 2'd0, '0, 64'd0, r);
    expect_dir("t1_tag", 64'(obs_tag), 64'd1);
    expect_dir("t1_data", obs_data, 64'd0);

    // T2: store then load the same address.
    step(1'b1, 2'd2, AW'(7), 64'hDEADBEEF, r);
    expect_dir("t2_store_resp", 64'(r), 64'd1);
    step(1'b1, 2'd1, AW'(7), 64'd0, r);
    expect_dir("t2_load_resp", 64'(r), 64'd2);
    idle(int'(LAT) - 2);
    step(1'b1, 2'd0, '0, 64'd0, r);
    expect_dir("t2_store_tag", 64'(obs_tag), 64'd1);
    step(1'b1, 2'd0, '0, 64'd0, r);
    expect_dir("t2_load_tag", 64'(obs_tag), 64'd2);
    expect_dir("t2_load_data", obs_data, 64'hDEADBEEF);
    drain();

    // T3: fill every slot, refuse while full, reuse tag 1 the cycle after it completes.
    for (int i = 0; i < int'(NT); i++) begin
      step(1'b1, 2'd1, AW'(i), 64'd0, r);
      expect_dir("t3_fill_resp", 64'(r), 64'(i + 1));
    end
    step(1'b1, 2'd1, AW'(20), 64'd0, r);
    expect_dir("t3_full_resp", 64'(r), 64'd0);
    step(1'b1, 2'd1, AW'(20), 64'd0, r);
    expect_dir("t3_bcast_cycle_resp", 64'(r), 64'd0);
    expect_dir("t3_bcast_tag", 64'(obs_tag), 64'd1);
    step(1'b1, 2'd1, AW'(20), 64'd0, r);
    expect_dir("t3_reuse_resp", 64'(r), 64'd1);
    drain();

    // T4: loads to two addresses keep their snapshot data despite a later overwrite.
    step(1'b1, 2'd2, AW'(1), 64'h1111_2222_3333_4444, r);
    step(1'b1, 2'd2, AW'(2), 64'h5555_6666_7777_8888, r);
    step(1'b1, 2'd1, AW'(1), 64'd0, r);
    step(1'b1, 2'd1, AW'(2), 64'd0, r);
    step(1'b1, 2'd2, AW'(1), 64'hFFFF_0000_FFFF_0000, r);
    step(1'b1, 2'd1, AW'(1), 64'd0, r);
    drain();

    // T5: reset with requests outstanding discards them; numbering restarts at 1.
    for (int i = 0; i < 3; i++) step(1'b1, 2'd1, AW'(i), 64'd0, r);
    step(1'b0, 2'd0, '0, 64'd0, r);
    step(1'b0, 2'd0, '0, 64'd0, r);
    idle(int'(LAT) + 2);
    expect_dir("t5_quiet_tag", 64'(obs_tag), 64'd0);
    step(1'b1, 2'd1, AW'(3), 64'd0, r);
    expect_dir("t5_restart_resp", 64'(r), 64'd1);
    drain();

    // T6: random commands over a small address window.
    for (int i = 0; i < 400; i++) begin
      step(1'b1, 2'($urandom_range(0, 3)), AW'($urandom_range(0, 15)),
           {32'($urandom), 32'($urandom)}, r);
    end
    drain();
    idle(2);
    check_eq("completions", 64'(n_observed), 64'(n_accepted - n_discarded));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
